bounce_axis_ctrl: RTL and testbench

BOUNCE_AXIS_CTRL -- requirements
Module: bounce_axis_ctrl

---
 rtl/bounce_axis_ctrl.sv | 155 +++++++++++++++
 tb/tb_bounce_axis_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_axis_ctrl.sv
// Purpose : single-axis bounce controller; issues one bounded-position request per frame_tick.
// Latency : frame_tick at edge E -> pos/speed/done/hit visible after edge E+2+LATENCY.
// Backpressure: none; a frame_tick while busy is dropped and recorded in the sticky overrun flag.
//
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   frame_tick, init           update request / synchronous load of init_pos, init_speed
//   init_pos, init_speed       load values (position unsigned, speed two's complement)
//   lower_bound, upper_bound   boundaries, forwarded via req_boundary
//   req_valid/dir/speed/boundary/pos   request to the bounded-position pipeline
//   resp_pos                   pipeline answer, valid LATENCY edges after the request edge
//   pos, speed                 registered axis state
//   busy, done, hit, hit_side, overrun  status
module bounce_axis_ctrl #(
  parameter int POS_LOG_SIZE = 10,
  parameter int LATENCY      = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    frame_tick,
  input  logic                    init,
  input  logic [POS_LOG_SIZE-1:0] init_pos,
  input  logic [POS_LOG_SIZE-1:0] init_speed,
  input  logic [POS_LOG_SIZE-1:0] lower_bound,
  input  logic [POS_LOG_SIZE-1:0] upper_bound,
  output logic                    req_valid,
  output logic                    req_dir,
  output logic [POS_LOG_SIZE-1:0] req_speed,
  output logic [POS_LOG_SIZE-1:0] req_boundary,
  output logic [POS_LOG_SIZE-1:0] req_pos,
  input  logic [POS_LOG_SIZE-1:0] resp_pos,
  output logic [POS_LOG_SIZE-1:0] pos,
  output logic [POS_LOG_SIZE-1:0] speed,
  output logic                    busy,
  output logic                    done,
  output logic                    hit,
  output logic                    hit_side,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  localparam logic [3:0] LP_WAIT_LOAD = 4'(LATENCY - 1);
  localparam logic [POS_LOG_SIZE-1:0] LP_MOST_NEG = {1'b1, {(POS_LOG_SIZE-1){1'b0}}};
  localparam logic [POS_LOG_SIZE-1:0] LP_MOST_POS = {1'b0, {(POS_LOG_SIZE-1){1'b1}}};
  localparam logic [POS_LOG_SIZE-1:0] LP_ONE      = POS_LOG_SIZE'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_wait_cnt;
  logic [POS_LOG_SIZE-1:0] r_result;
  logic [POS_LOG_SIZE-1:0] r_pos;
  logic [POS_LOG_SIZE-1:0] r_speed;
  logic                    r_done;
  logic                    r_hit;
  logic                    r_hit_side;
  logic                    r_overrun;

  logic                    w_req_dir;
  logic [POS_LOG_SIZE-1:0] w_boundary;
  logic                    w_hit;
  logic [POS_LOG_SIZE-1:0] w_neg_speed;

  // Zero speed counts as moving toward the upper bound.
  assign w_req_dir   = ~r_speed[POS_LOG_SIZE-1];
  assign w_boundary  = w_req_dir ? upper_bound : lower_bound;
  // A stationary axis resting on a bound is not a contact.
  assign w_hit       = (r_result == w_boundary) && (r_speed != '0);
  // Negating the most-negative value would overflow back to itself; clamp instead.
  assign w_neg_speed = (r_speed == LP_MOST_NEG) ? LP_MOST_POS : (~r_speed + LP_ONE);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; init overrides everything and abandons any in-flight request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (frame_tick) w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT:   if (r_wait_cnt == 4'd0) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (init) w_state_nxt = S_IDLE;
  end

  // Datapath and status registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wait_cnt <= '0;
      r_result   <= '0;
      r_pos      <= '0;
      r_speed    <= '0;
      r_done     <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_side <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_hit  <= 1'b0;
      if (init) begin
        r_pos      <= init_pos;
        r_speed    <= init_speed;
        r_overrun  <= 1'b0;
        r_wait_cnt <= '0;
      end else begin
        if (frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
        case (r_state)
          S_ISSUE: r_wait_cnt <= LP_WAIT_LOAD;
          S_WAIT: begin
            if (r_wait_cnt == 4'd0) r_result <= resp_pos;
            else                    r_wait_cnt <= r_wait_cnt - 4'd1;
          end
          S_UPDATE: begin
            r_pos  <= r_result;
            r_done <= 1'b1;
            if (w_hit) begin
              r_hit      <= 1'b1;
              r_hit_side <= w_req_dir;
              r_speed    <= w_neg_speed;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // req_* come straight from pos/speed, which cannot change between ISSUE and UPDATE.
  assign req_valid    = (r_state == S_ISSUE);
  assign req_dir      = w_req_dir;
  assign req_speed    = r_speed;
  assign req_boundary = w_boundary;
  assign req_pos      = r_pos;
  assign pos          = r_pos;
  assign speed        = r_speed;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign hit          = r_hit;
  assign hit_side     = r_hit_side;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_bounce_axis_ctrl.sv
module tb_bounce_axis_ctrl;
  localparam int W = 10;
  localparam int L = 2;
  localparam logic [W-1:0] LB = 10'd8;
  localparam logic [W-1:0] UB = 10'd600;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         frame_tick = 1'b0;
  logic         init = 1'b0;
  logic [W-1:0] init_pos = '0;
  logic [W-1:0] init_speed = '0;
  logic [W-1:0] lower_bound = LB;
  logic [W-1:0] upper_bound = UB;
  logic [W-1:0] resp_pos;
  logic         req_valid, req_dir, busy, done, hit, hit_side, overrun;
  logic [W-1:0] req_speed, req_boundary, req_pos, pos, speed;

  int errs = 0;
  int checks = 0;

  bounce_axis_ctrl #(.POS_LOG_SIZE(W), .LATENCY(L)) dut (
    .CLK(CLK), .RST_N(RST_N), .frame_tick(frame_tick), .init(init),
    .init_pos(init_pos), .init_speed(init_speed),
    .lower_bound(lower_bound), .upper_bound(upper_bound),
    .req_valid(req_valid), .req_dir(req_dir), .req_speed(req_speed),
    .req_boundary(req_boundary), .req_pos(req_pos), .resp_pos(resp_pos),
    .pos(pos), .speed(speed), .busy(busy), .done(done), .hit(hit),
    .hit_side(hit_side), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  // Pipeline stand-in: answer is present only in the cycle before edge (request edge + L).
  logic [W-1:0] resp_tgt = '0;
  logic [L-1:0] pipe = '0;
  always @(posedge CLK) pipe <= {pipe[L-2:0], req_valid};
  assign resp_pos = pipe[L-1] ? resp_tgt : 10'h2AA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k counts edges since an accepted tick (0 = idle).
  int           m_k = 0;
  logic [W-1:0] m_pos = '0, m_spd = '0, m_res = '0;
  logic         m_done = 0, m_hit = 0, m_side = 0, m_ovr = 0;

  function automatic logic [W-1:0] bound_of(input logic [W-1:0] s);
    return ($signed(s) >= 0) ? UB : LB;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_k = 0; m_pos = '0; m_spd = '0; m_res = '0;
      m_done = 0; m_hit = 0; m_side = 0; m_ovr = 0;
    end else begin
      m_done = 0;
      m_hit = 0;
      if (init) begin
        m_pos = init_pos; m_spd = init_speed; m_ovr = 0; m_k = 0;
      end else if (m_k == 0) begin
        if (frame_tick) m_k = 1;
      end else begin
        if (frame_tick) m_ovr = 1;
        if (m_k == L + 1) m_res = resp_pos;
        if (m_k == L + 2) begin
          int s;
          m_pos = m_res;
          m_done = 1;
          if (m_res == bound_of(m_spd) && m_spd != 0) begin
            m_hit = 1;
            m_side = ($signed(m_spd) >= 0);
            s = -int'($signed(m_spd));
            if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
            m_spd = s[W-1:0];
          end
          m_k = 0;
        end else begin
          m_k++;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("m_req_valid", 32'(req_valid), 32'(m_k == 1));
    chk("m_busy", 32'(busy), 32'(m_k != 0));
    chk("m_req_dir", 32'(req_dir), 32'($signed(m_spd) >= 0));
    chk("m_req_boundary", 32'(req_boundary), 32'(bound_of(m_spd)));
    chk("m_req_pos", 32'(req_pos), 32'(m_pos));
    chk("m_req_speed", 32'(req_speed), 32'(m_spd));
    chk("m_pos", 32'(pos), 32'(m_pos));
    chk("m_speed", 32'(speed), 32'(m_spd));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_hit", 32'(hit), 32'(m_hit));
    chk("m_hit_side", 32'(hit_side), 32'(m_side));
    chk("m_overrun", 32'(overrun), 32'(m_ovr));
  end

  task automatic do_init(input logic [W-1:0] p, input logic [W-1:0] s);
    @(negedge CLK);
    init = 1; init_pos = p; init_speed = s;
    @(negedge CLK);
    init = 0;
  endtask

  // Tick at negedge n0; request visible at n1; done visible at n5.
  task automatic run_tx(input logic [W-1:0] tgt, input logic exp_dir,
                        input logic [W-1:0] exp_bnd, input logic exp_hit);
    resp_tgt = tgt;
    @(negedge CLK);
    frame_tick = 1;
    @(negedge CLK);
    frame_tick = 0;
    chk("lit_req_valid", 32'(req_valid), 32'd1);
    chk("lit_req_dir", 32'(req_dir), 32'(exp_dir));
    chk("lit_req_boundary", 32'(req_boundary), 32'(exp_bnd));
    repeat (3) @(negedge CLK);
    chk("lit_done_early", 32'(done), 32'd0);
    @(negedge CLK);
    chk("lit_done", 32'(done), 32'd1);
    chk("lit_hit", 32'(hit), 32'(exp_hit));
    @(negedge CLK);
    chk("lit_done_single", 32'(done), 32'd0);
  endtask

  initial begin
    #1 RST_N = 0;
    @(negedge CLK);
    chk("lit_rst_pos", 32'(pos), 32'd0);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST_N = 1;

    // Free motion toward upper bound
    do_init(10'd100, 10'd5);
    run_tx(10'd105, 1'b1, UB, 1'b0);
    chk("lit_A_pos", 32'(pos), 32'd105);
    chk("lit_A_speed", 32'(speed), 32'd5);

    // Upper-bound contact reverses speed
    do_init(10'd598, 10'd5);
    run_tx(10'd600, 1'b1, UB, 1'b1);
    chk("lit_B_pos", 32'(pos), 32'd600);
    chk("lit_B_speed", 32'(speed), 32'h3FB);
    chk("lit_B_side", 32'(hit_side), 32'd1);

    // No contact: hit_side holds
    do_init(10'd100, 10'd5);
    run_tx(10'd105, 1'b1, UB, 1'b0);
    chk("lit_C_side_hold", 32'(hit_side), 32'd1);

    // Reset mid-WAIT
    do_init(10'd100, 10'd5);
    resp_tgt = 10'd105;
    @(negedge CLK);
    frame_tick = 1;
    @(negedge CLK);
    frame_tick = 0;
    @(negedge CLK);
    chk("lit_R_busy_before", 32'(busy), 32'd1);
    #2 RST_N = 0;
    #1;
    chk("lit_R_pos", 32'(pos), 32'd0);
    chk("lit_R_speed", 32'(speed), 32'd0);
    chk("lit_R_busy", 32'(busy), 32'd0);
    chk("lit_R_side", 32'(hit_side), 32'd0);
    chk("lit_R_valid", 32'(req_valid), 32'd0);
    @(negedge CLK);
    RST_N = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("lit_R_no_done", 32'(done), 32'd0);
    end

    // Lower-bound contact
    do_init(10'd10, 10'h3FD);
    run_tx(10'd8, 1'b0, LB, 1'b1);
    chk("lit_D_speed", 32'(speed), 32'd3);
    chk("lit_D_side", 32'(hit_side), 32'd0);

    // Most-negative speed saturates
    do_init(10'd9, 10'h200);
    run_tx(10'd8, 1'b0, LB, 1'b1);
    chk("lit_E_speed", 32'(speed), 32'd511);

    // Tick during WAIT -> overrun, single done
    do_init(10'd100, 10'd5);
    resp_tgt = 10'd105;
    @(negedge CLK);
    frame_tick = 1;
    @(negedge CLK);
    frame_tick = 0;
    @(negedge CLK);
    frame_tick = 1;
    @(negedge CLK);
    frame_tick = 0;
    chk("lit_O_overrun", 32'(overrun), 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("lit_O_done", 32'(done), 32'd1);
    @(negedge CLK);
    chk("lit_O_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    chk("lit_O_no_second", 32'(req_valid), 32'd0);

    // init with simultaneous tick wins
    @(negedge CLK);
    init = 1; frame_tick = 1; init_pos = 10'd50; init_speed = 10'd2;
    @(negedge CLK);
    init = 0; frame_tick = 0;
    chk("lit_I_busy", 32'(busy), 32'd0);
    chk("lit_I_overrun", 32'(overrun), 32'd0);
    chk("lit_I_pos", 32'(pos), 32'd50);
    @(negedge CLK);
    chk("lit_I_no_req", 32'(req_valid), 32'd0);

    // Zero speed resting on a bound
    do_init(10'd600, 10'd0);
    run_tx(10'd600, 1'b1, UB, 1'b0);
    chk("lit_Z_speed", 32'(speed), 32'd0);
    chk("lit_Z_pos", 32'(pos), 32'd600);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
